// File: rtl/ser_pkg.sv
// Shared constants, state encoding and the enabled-lane priority scan for the byte serializer.
package ser_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } scan_t;

  // Lane idx 0 is A[31:24] (enable bit 3); the scan walks lanes in send order
  // starting at p (inclusive) or just after p, and returns the first enabled lane.
  function automatic scan_t next_lane(input logic [3:0] be, input logic [1:0] p,
                                      input logic msb_first, input logic incl);
    scan_t      r;
    logic [1:0] pos;
    logic [2:0] start;
    logic [1:0] lane;
    r     = '0;
    pos   = msb_first ? p : 2'd3 - p;
    start = incl ? {1'b0, pos} : {1'b0, pos} + 3'd1;
    for (int o = WORD_BYTES - 1; o >= 0; o--) begin
      lane = msb_first ? o[1:0] : 2'd3 - o[1:0];
      if (({1'b0, o[1:0]} >= start) && be[2'd3 - lane]) begin
        r.found = 1'b1;
        r.idx   = lane;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/splitter.sv
// Byte-lane extractor: o1 = a[31:24] ... o4 = a[7:0]; purely combinational, no flow control.
module splitter
  import ser_pkg::*;
(
  input  logic [BYTE_W*WORD_BYTES-1:0] a,
  output logic [BYTE_W-1:0]            o1,
  output logic [BYTE_W-1:0]            o2,
  output logic [BYTE_W-1:0]            o3,
  output logic [BYTE_W-1:0]            o4
);

  assign o1 = a[31:24];
  assign o2 = a[23:16];
  assign o3 = a[15:8];
  assign o4 = a[7:0];

endmodule

// File: rtl/word_byte_serializer.sv
// Word-to-byte serializer: first byte 1 cycle after accept, one enabled byte per cycle.
// Holds the current byte under out_ready=0; in_ready opens combinationally on the last byte taken.
module word_byte_serializer
  import ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  input  logic [3:0]       in_be,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic [0:0]  state;
  logic [31:0] word;
  logic [3:0]  mask;
  logic [1:0]  idx;
  logic [7:0]  o1, o2, o3, o4;
  scan_t       nxt, first;
  logic        fire, accept;

  splitter u_split (
    .a  (word),
    .o1 (o1),
    .o2 (o2),
    .o3 (o3),
    .o4 (o4)
  );

  assign nxt   = next_lane(mask, idx, MSB_FIRST, 1'b0);
  assign first = next_lane(in_be, MSB_FIRST ? 2'd0 : 2'd3, MSB_FIRST, 1'b1);

  assign out_valid = (state == ST_SEND);
  assign busy      = out_valid;
  assign out_last  = out_valid && !nxt.found;
  assign fire      = out_valid && out_ready;
  // Finishing the last byte frees the holding slot in the same cycle, so words stream without a bubble.
  assign in_ready  = !reset && ((state == ST_IDLE) || (fire && out_last));
  assign accept    = in_valid && in_ready;

  always_comb begin
    out_data = o1;
    case (idx)
      2'd0:    out_data = o1;
      2'd1:    out_data = o2;
      2'd2:    out_data = o3;
      default: out_data = o4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      word       <= '0;
      mask       <= '0;
      idx        <= '0;
      byte_count <= '0;
    end else begin
      if (fire) byte_count <= byte_count + CNT_W'(1);
      if (accept) begin
        if (in_be != 4'd0) begin
          state <= ST_SEND;
          word  <= in_word;
          mask  <= in_be;
          idx   <= first.idx;
        end else begin
          state <= ST_IDLE;
        end
      end else if (fire) begin
        if (out_last) state <= ST_IDLE;
        else          idx   <= nxt.idx;
      end
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench: an MSB-first and an LSB-first (narrow counter) instance share one stimulus stream.
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_word;
  logic [3:0]  in_be;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic [15:0] byte_count;

  logic        l_in_ready, l_out_valid, l_out_last, l_busy;
  logic [7:0]  l_out_data;
  logic [2:0]  l_byte_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  word_byte_serializer #(.MSB_FIRST(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_be(in_be), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .byte_count(byte_count)
  );

  word_byte_serializer #(.MSB_FIRST(1'b0), .CNT_W(3)) dut_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_word(in_word), .in_be(in_be), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_data(l_out_data), .out_last(l_out_last), .busy(l_busy), .byte_count(l_byte_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  // Call with inputs free to change (after an edge); returns at posedge+1 with the word accepted.
  task automatic offer(input logic [31:0] w, input logic [3:0] be);
    in_word  = w;
    in_be    = be;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = 32'h5A5A_5A5A;
    in_be    = 4'hF;
  endtask

  // Expects n bytes on consecutive cycles; bytes listed first-at-MSB in em (msb dut) and el (lsb dut).
  task automatic collect(input string tag, input int n, input logic [31:0] em, input logic [31:0] el);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_dat"}, {24'd0, out_data}, {24'd0, em[31-8*i -: 8]});
      check({tag, "_last"}, {31'd0, out_last}, {31'd0, (i == n - 1)});
      check({tag, "_ldat"}, {24'd0, l_out_data}, {24'd0, el[31-8*i -: 8]});
      check({tag, "_llast"}, {31'd0, l_out_last}, {31'd0, (i == n - 1)});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] seq_m, seq_l;
    logic [31:0] stall_w;
    int k;
    reset = 1'b1; in_valid = 1'b0; in_word = '0; in_be = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, byte_count}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Full word, both byte orders.
    out_ready = 1'b1;
    offer(32'h1122_3344, 4'hF);
    collect("w1", 4, 32'h1122_3344, 32'h4433_2211);
    @(negedge clk);
    check("w1_idle", {31'd0, out_valid}, 32'd0);
    check("w1_count", {16'd0, byte_count}, 32'd4);
    check("w1_lcount", {29'd0, l_byte_count}, 32'd4);

    // Sparse enables skip lanes without gaps.
    offer(32'hA1B2_C3D4, 4'b1010);
    collect("w2", 2, 32'hA1C3_0000, 32'hC3A1_0000);
    in_word = 32'hFFFF_FFFF; in_be = 4'h0; in_valid = 1'b1;
    @(negedge clk);
    check("be0_rdy_pre", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("be0_vld", {31'd0, out_valid}, 32'd0);
    check("be0_rdy", {31'd0, in_ready}, 32'd1);
    check("be0_count", {16'd0, byte_count}, 32'd6);

    // Back-to-back words; in_ready pulses only on the last byte of each word.
    seq_m = 64'h0102_0304_0506_0708;
    seq_l = 64'h0403_0201_0807_0605;
    offer(32'h0102_0304, 4'hF);
    in_word = 32'h0506_0708; in_be = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_vld", {31'd0, out_valid}, 32'd1);
      check("b2b_dat", {24'd0, out_data}, {24'd0, seq_m[63-8*i -: 8]});
      check("b2b_ldat", {24'd0, l_out_data}, {24'd0, seq_l[63-8*i -: 8]});
      check("b2b_last", {31'd0, out_last}, {31'd0, (i == 3 || i == 7)});
      check("b2b_rdy", {31'd0, in_ready}, {31'd0, (i == 3 || i == 7)});
      @(posedge clk);
      #1;
      if (i == 3) begin in_valid = 1'b0; in_word = 32'h0BAD_0BAD; end
    end
    @(negedge clk);
    check("b2b_idle", {31'd0, out_valid}, 32'd0);
    check("b2b_count", {16'd0, byte_count}, 32'd14);
    check("b2b_lcount_wrap", {29'd0, l_byte_count}, 32'd6);

    // Stalls: data and last hold while out_ready is low.
    stall_w = 32'hDEAD_BEEF;
    offer(stall_w, 4'hF);
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      out_ready = (c % 3 == 0);
      @(negedge clk);
      check("stall_vld", {31'd0, out_valid}, 32'd1);
      check("stall_dat", {24'd0, out_data}, {24'd0, stall_w[31-8*k -: 8]});
      check("stall_last", {31'd0, out_last}, {31'd0, (k == 3)});
      @(posedge clk);
      if (out_ready) k++;
      #1;
    end
    check("stall_done", k, 32'd4);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_count", {16'd0, byte_count}, 32'd18);
    check("stall_lcount", {29'd0, l_byte_count}, 32'd2);

    // Reset in the middle of a word.
    offer(32'hCAFE_F00D, 4'hF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_dat", {24'd0, out_data}, (i == 0) ? 32'hCA : 32'hFE);
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {16'd0, byte_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rel_rdy", {31'd0, in_ready}, 32'd1);
    offer(32'h0000_00FF, 4'h1);
    collect("post", 1, 32'hFF00_0000, 32'hFF00_0000);
    @(negedge clk);
    check("post_idle", {31'd0, out_valid}, 32'd0);
    check("post_count", {16'd0, byte_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
